// File: rtl/cdma_gold_multi.sv
// Multi-channel Gold-code CDMA spreader with a single-channel correlating despreader.
// Chips advance once every CHIP_DIV clocks; each user sends one bit per 2^DEG-1 chip period.
module cdma_gold_multi #(
  parameter int             CHANNELS = 2,
  parameter int             DEG      = 5,
  parameter logic [DEG-1:0] POLY_A   = 5'b00101,
  parameter logic [DEG-1:0] POLY_B   = 5'b01111,
  parameter logic [23:0]    CHIP_DIV = 24'd10_000_000,
  localparam int            L        = (1 << DEG) - 1,
  localparam int            CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int            SUM_W    = $clog2(CHANNELS + 1),
  localparam int            ACC_W    = $clog2(L * CHANNELS + 1) + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    load_i,
  input  logic [CHANNELS*DEG-1:0] seed_i,
  input  logic [CHANNELS-1:0]     data_i,
  input  logic [CH_W-1:0]         sel_i,
  input  logic                    loop_i,
  input  logic                    rx_chip_i,
  output logic [CHANNELS-1:0]     chip_o,
  output logic [CHANNELS-1:0]     gold_o,
  output logic [SUM_W-1:0]        sum_o,
  output logic                    chip_stb_o,
  output logic                    sym_stb_o,
  output logic                    rx_bit_o,
  output logic                    rx_valid_o,
  output logic                    led_o
);

  localparam int             DIV_W    = $clog2(CHIP_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CHIP_DIV - 24'd1);
  localparam logic [DEG-1:0] IDX_LAST = DEG'(L - 1);

  logic [DIV_W-1:0]        div_cnt_reg;
  logic [DEG-1:0]          idx_reg;
  logic [CHANNELS*DEG-1:0] lfsr_a_reg, lfsr_a_next, seed_fixed;
  logic [DEG-1:0]          lfsr_b_reg, lfsr_b_next;
  logic [CHANNELS-1:0]     data_reg, gold, chips;
  logic signed [ACC_W-1:0] acc_reg, acc_next, corr_c;
  logic                    chip_stb_reg, sym_stb_reg, rx_bit_reg, rx_valid_reg, led_reg;
  logic                    tick, wrap, gold_sel;
  logic [CH_W-1:0]         sel_eff;
  logic [SUM_W-1:0]        sum, rx_level;

  assign tick        = (div_cnt_reg == DIV_LAST);
  assign wrap        = tick && (idx_reg == IDX_LAST);
  assign lfsr_b_next = {^(lfsr_b_reg & POLY_B), lfsr_b_reg[DEG-1:1]};

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [DEG-1:0] a_cur, seed_k;
      assign a_cur  = lfsr_a_reg[gi*DEG +: DEG];
      assign seed_k = seed_i[gi*DEG +: DEG];
      assign lfsr_a_next[gi*DEG +: DEG] = {^(a_cur & POLY_A), a_cur[DEG-1:1]};
      // An all-zero seed would lock the LFSR, so it is promoted to 1.
      assign seed_fixed[gi*DEG +: DEG]  = (seed_k == '0) ? DEG'(1) : seed_k;
      assign gold[gi] = a_cur[0] ^ lfsr_b_reg[0];
    end
  endgenerate

  assign chips = data_reg ^ gold;

  always_comb begin
    sum = '0;
    for (int i = 0; i < CHANNELS; i++) sum = sum + SUM_W'(chips[i]);
  end

  // Out-of-range selects fall back to channel 0.
  always_comb begin
    sel_eff  = (int'(sel_i) >= CHANNELS) ? '0 : sel_i;
    gold_sel = 1'b0;
    for (int i = 0; i < CHANNELS; i++)
      if (sel_eff == CH_W'(i)) gold_sel = gold[i];
  end

  // Received level mapped to a bipolar sample in [-CHANNELS, +CHANNELS].
  assign rx_level = loop_i ? sum : (rx_chip_i ? SUM_W'(CHANNELS) : '0);
  assign corr_c   = (ACC_W'(rx_level) << 1) - ACC_W'(CHANNELS);
  assign acc_next = gold_sel ? (acc_reg + corr_c) : (acc_reg - corr_c);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt_reg  <= '0;
      idx_reg      <= '0;
      acc_reg      <= '0;
      lfsr_a_reg   <= {CHANNELS{DEG'(1)}};
      lfsr_b_reg   <= '1;
      data_reg     <= '0;
      chip_stb_reg <= 1'b0;
      sym_stb_reg  <= 1'b0;
      rx_bit_reg   <= 1'b0;
      rx_valid_reg <= 1'b0;
      led_reg      <= 1'b0;
    end else begin
      chip_stb_reg <= 1'b0;
      sym_stb_reg  <= 1'b0;
      rx_valid_reg <= 1'b0;
      if (load_i) begin
        div_cnt_reg <= '0;
        idx_reg     <= '0;
        acc_reg     <= '0;
        lfsr_a_reg  <= seed_fixed;
        lfsr_b_reg  <= '1;
        data_reg    <= data_i;
      end else begin
        div_cnt_reg <= tick ? '0 : div_cnt_reg + 1'b1;
        if (tick) begin
          chip_stb_reg <= 1'b1;
          lfsr_a_reg   <= lfsr_a_next;
          lfsr_b_reg   <= lfsr_b_next;
          if (wrap) begin
            idx_reg      <= '0;
            acc_reg      <= '0;
            data_reg     <= data_i;
            sym_stb_reg  <= 1'b1;
            rx_bit_reg   <= acc_next[ACC_W-1];
            rx_valid_reg <= 1'b1;
            led_reg      <= ~led_reg;
          end else begin
            idx_reg <= idx_reg + 1'b1;
            acc_reg <= acc_next;
          end
        end
      end
    end
  end

  assign chip_o     = chips;
  assign gold_o     = gold;
  assign sum_o      = sum;
  assign chip_stb_o = chip_stb_reg;
  assign sym_stb_o  = sym_stb_reg;
  assign rx_bit_o   = rx_bit_reg;
  assign rx_valid_o = rx_valid_reg;
  assign led_o      = led_reg;

endmodule

// File: tb/tb_cdma_gold_multi.sv
// Bench for cdma_gold_multi: three users, four clocks per chip, code tables built from the LFSR rules.
// Every cycle is compared against a chip/symbol-level model; table rows add fixed expectations.
module tb_cdma_gold_multi;

  localparam int CH  = 3;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        load_i = 1'b0;
  logic [14:0] seed_i = '0;
  logic [2:0]  data_i = '0;
  logic [1:0]  sel_i = '0;
  logic        loop_i = 1'b0;
  logic        rx_chip_i = 1'b0;
  logic [2:0]  chip_o, gold_o;
  logic [1:0]  sum_o;
  logic        chip_stb_o, sym_stb_o, rx_bit_o, rx_valid_o, led_o;

  cdma_gold_multi #(
    .CHANNELS(CH), .DEG(5), .POLY_A(5'b00101), .POLY_B(5'b01111), .CHIP_DIV(24'd4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .load_i(load_i), .seed_i(seed_i), .data_i(data_i),
    .sel_i(sel_i), .loop_i(loop_i), .rx_chip_i(rx_chip_i), .chip_o(chip_o), .gold_o(gold_o),
    .sum_o(sum_o), .chip_stb_o(chip_stb_o), .sym_stb_o(sym_stb_o), .rx_bit_o(rx_bit_o),
    .rx_valid_o(rx_valid_o), .led_o(led_o)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail = 0;
  bit         gtab [CH][31];
  int         k, chip_n, macc;
  bit         m_led, m_rxb;
  logic [2:0] m_data;
  logic [2:0] dq[$];
  bit         rx_log[$];

  typedef struct {
    logic [14:0] seeds;
    logic [1:0]  sel;
    int          src;
    logic [11:0] data;   // symbol m at [m*3 +: 3]
    logic [3:0]  expv;   // expected rx_bit_o of symbol m at bit m
  } vec_t;
  vec_t tv [4];

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void build_gold(input logic [14:0] s);
    logic [4:0] a, b;
    for (int ch = 0; ch < CH; ch++) begin
      a = s[ch*5 +: 5];
      if (a == 5'd0) a = 5'd1;
      b = 5'h1f;
      for (int j = 0; j < 31; j++) begin
        gtab[ch][j] = a[0] ^ b[0];
        a = {^(a & 5'b00101), a[4:1]};
        b = {^(b & 5'b01111), b[4:1]};
      end
    end
  endfunction

  function automatic logic [2:0] gvec(input int n);
    logic [2:0] g;
    for (int ch = 0; ch < CH; ch++) g[ch] = gtab[ch][n % 31];
    return g;
  endfunction

  function automatic int popc3(input logic [2:0] v);
    return int'(v[0]) + int'(v[1]) + int'(v[2]);
  endfunction

  task automatic reset_model();
    k = 0; chip_n = 0; macc = 0; m_data = '0; m_led = 1'b0;
    dq.delete();
    build_gold(15'b00001_00001_00001);
  endtask

  // One clock: predict tick/decision from cycles since load, then compare after the edge.
  task automatic cycle(input bit do_load);
    bit tk, sy, vl;
    int idx, r, c, s;
    tk = !do_load && (k % DIV == DIV - 1);
    sy = 1'b0; vl = 1'b0;
    load_i = do_load;
    if (tk) begin
      idx = chip_n % 31;
      r = loop_i ? popc3(m_data ^ gvec(chip_n)) : (rx_chip_i ? CH : 0);
      c = 2 * r - CH;
      s = (int'(sel_i) >= CH) ? 0 : int'(sel_i);
      macc += gtab[s][idx] ? c : -c;
      chip_n++;
      if (idx == 30) begin
        sy = 1'b1; vl = 1'b1;
        m_rxb = (macc < 0);
        macc = 0;
        m_led = !m_led;
        m_data = data_i;
      end
    end
    if (do_load) begin
      k = 0; chip_n = 0; macc = 0; m_data = data_i;
      build_gold(seed_i);
    end else begin
      k++;
    end
    @(posedge clk); #1;
    load_i = 1'b0;
    chk("chip_stb", int'(chip_stb_o), int'(tk));
    chk("sym_stb", int'(sym_stb_o), int'(sy));
    chk("rx_valid", int'(rx_valid_o), int'(vl));
    chk("led", int'(led_o), int'(m_led));
    chk("gold", int'(gold_o), int'(gvec(chip_n)));
    chk("chip", int'(chip_o), int'(m_data ^ gvec(chip_n)));
    chk("sum", int'(sum_o), popc3(m_data ^ gvec(chip_n)));
    if (vl) begin
      chk("rx_bit", int'(rx_bit_o), int'(m_rxb));
      rx_log.push_back(rx_bit_o);
    end
    if (sy && dq.size() > 0) data_i = dq.pop_front();
  endtask

  // mode 0: loopback; 1: external chip = inverted chip of channel src; 2: random external chips
  task automatic run_chips(input int nchips, input int mode, input int src, input bit rand_sel);
    int target;
    target = chip_n + nchips;
    for (int i = 0; i < nchips * DIV + 8 && chip_n < target; i++) begin
      if (mode == 1) rx_chip_i = ~(m_data[src] ^ gtab[src][chip_n % 31]);
      else if (mode == 2) rx_chip_i = 1'($urandom_range(0, 1));
      if (rand_sel) sel_i = 2'($urandom_range(0, 3));
      cycle(1'b0);
    end
  endtask

  task automatic do_load(input logic [14:0] s, input logic [2:0] d0, input logic [2:0] d1);
    seed_i = s;
    data_i = d0;
    cycle(1'b1);
    data_i = d1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rst_chip"}, int'(chip_o), 0);
    chk({tag, "_rst_gold"}, int'(gold_o), 0);
    chk({tag, "_rst_sum"}, int'(sum_o), 0);
    chk({tag, "_rst_stb"}, int'({chip_stb_o, sym_stb_o, rx_valid_o}), 0);
    chk({tag, "_rst_rx_led"}, int'({rx_bit_o, led_o}), 0);
  endtask

  task automatic check_first_stb(input string tag);
    int lat;
    lat = 0;
    do begin
      cycle(1'b0);
      lat++;
    end while (chip_stb_o !== 1'b1 && lat < 20);
    chk({tag, "_first_stb_latency"}, lat, DIV);
  endtask

  initial begin
    int lat;
    tv[0] = '{seeds: {5'b01010, 5'b00111, 5'b00001}, sel: 2'd0, src: 0,
              data: {3'b010, 3'b011, 3'b000, 3'b001}, expv: 4'b1010};
    tv[1] = '{seeds: {5'b01010, 5'b00111, 5'b00001}, sel: 2'd1, src: 1,
              data: {3'b000, 3'b110, 3'b010, 3'b001}, expv: 4'b1001};
    tv[2] = '{seeds: {5'b11000, 5'b00111, 5'b00001}, sel: 2'd3, src: 0,
              data: {3'b110, 3'b011, 3'b100, 3'b101}, expv: 4'b1010};
    tv[3] = '{seeds: {5'b00000, 5'b10101, 5'b00011}, sel: 2'd2, src: 2,
              data: {3'b000, 3'b100, 3'b100, 3'b000}, expv: 4'b1001};

    // Power-on reset, then first strobe latency.
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    @(negedge clk);
    rst_ni = 1'b1;
    reset_model();
    check_first_stb("por");

    // Reset asserted in the middle of a chip count.
    do_load(15'b00011_00101_00001, 3'b101, 3'b101);
    repeat (6) cycle(1'b0);
    rst_ni = 1'b0;
    #1;
    check_reset("mid");
    @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    reset_model();
    check_first_stb("mid");

    // Table: external path fed with the inverted chip of the selected user.
    loop_i = 1'b0;
    for (int t = 0; t < 4; t++) begin
      sel_i = tv[t].sel;
      rx_log.delete();
      dq.delete();
      dq.push_back(tv[t].data[6 +: 3]);
      dq.push_back(tv[t].data[9 +: 3]);
      do_load(tv[t].seeds, tv[t].data[0 +: 3], tv[t].data[3 +: 3]);
      run_chips(124, 1, tv[t].src, 1'b0);
      chk($sformatf("vec%0d_n_decisions", t), rx_log.size(), 4);
      for (int m = 0; m < 4 && m < rx_log.size(); m++)
        chk($sformatf("vec%0d_rx%0d", t, m), int'(rx_log[m]), int'(tv[t].expv[m]));
      $display("vector %0d sel=%0d decisions checked", t, tv[t].sel);
    end

    // Code sequence over two periods, loopback, user 0 seeded with 1.
    loop_i = 1'b1;
    sel_i = 2'd0;
    dq.delete();
    do_load(15'b00111_00011_00001, 3'b000, 3'b000);
    run_chips(62, 0, 0, 1'b0);
    $display("code sequence run: %0d chips", chip_n);

    // Randomized rounds: loopback or random external chips, some with per-chip select changes.
    for (int r = 0; r < 6; r++) begin
      loop_i = 1'(r % 2 == 0);
      sel_i = 2'($urandom_range(0, 3));
      dq.delete();
      dq.push_back(3'($urandom_range(0, 7)));
      do_load(15'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      run_chips(93, loop_i ? 0 : 2, 0, r >= 4);
      $display("random round %0d loop=%0d done", r, loop_i);
    end

    // Load mid-symbol at index 15, coinciding with a tick, with a zero seed on user 0.
    loop_i = 1'b1;
    sel_i = 2'd0;
    dq.delete();
    do_load(15'b00101_01001_00000, 3'b001, 3'b001);
    run_chips(15, 0, 0, 1'b0);
    for (int i = 0; i < 8 && (k % DIV) != DIV - 1; i++) cycle(1'b0);
    do_load(15'b01101_00110_00000, 3'b010, 3'b011);
    lat = 0;
    do begin
      cycle(1'b0);
      lat++;
    end while (rx_valid_o !== 1'b1 && lat < 200);
    chk("load_to_valid", lat, 31 * DIV);
    $display("mid-symbol load: decision after %0d clocks", lat);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
